// File: rtl/serv_wb_arbiter.sv
// serv_wb_arbiter: Wishbone-classic N-master to one-slave arbiter with
// fixed-priority or round-robin grant and per-transaction ack timeout.
module serv_wb_arbiter #(
    parameter int N_MASTERS = 3,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RR_MODE   = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic [N_MASTERS*AW-1:0] i_m_adr,
    input  logic [N_MASTERS*DW-1:0] i_m_dat,
    input  logic [N_MASTERS*(DW/8)-1:0] i_m_sel,
    input  logic [N_MASTERS-1:0]    i_m_we,
    input  logic [N_MASTERS-1:0]    i_m_cyc,
    input  logic [N_MASTERS-1:0]    i_m_stb,
    output logic [DW-1:0]           o_m_rdt,
    output logic [N_MASTERS-1:0]    o_m_ack,
    output logic [N_MASTERS-1:0]    o_m_err,
    output logic [AW-1:0]           o_s_adr,
    output logic [DW-1:0]           o_s_dat,
    output logic [DW/8-1:0]         o_s_sel,
    output logic                    o_s_we,
    output logic                    o_s_cyc,
    output logic                    o_s_stb,
    input  logic [DW-1:0]           i_s_rdt,
    input  logic                    i_s_ack,
    output logic [N_MASTERS-1:0]    o_grant,
    output logic                    o_timeout,
    input  logic                    i_timeout_clr
);
    localparam int SW = DW / 8;
    localparam int IW = $clog2(N_MASTERS);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]           r_state;
    logic [N_MASTERS-1:0] r_grant;
    logic [IW-1:0]        r_gidx;
    logic [IW-1:0]        r_last;
    logic [CW-1:0]        r_cnt;
    logic                 r_timeout;
    logic [N_MASTERS-1:0] w_req;
    logic [IW-1:0]        w_win;
    logic                 w_busy;
    logic                 w_ack;
    logic                 w_to;
    logic                 w_abort;

    assign w_req   = i_m_cyc & i_m_stb;
    assign w_busy  = r_state == BUSY;
    assign w_ack   = w_busy & i_s_ack;
    assign w_to    = TIMEOUT > 0 && w_busy && !i_s_ack && r_cnt == CW'(TIMEOUT);
    assign w_abort = w_busy & ~i_m_cyc[r_gidx];

    // Round-robin searches upward from last+1; fixed priority from index 0.
    always_comb begin : sel
        int k;
        logic found;
        k = 0;
        found = 1'b0;
        w_win = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            k = RR_MODE != 0 ? (int'(r_last) + 1 + j) % N_MASTERS : j;
            if (!found && w_req[k]) begin
                w_win = IW'(k);
                found = 1'b1;
            end
        end
    end

    assign o_s_cyc   = w_busy;
    assign o_s_stb   = w_busy;
    assign o_s_adr   = w_busy ? i_m_adr[r_gidx*AW +: AW] : '0;
    assign o_s_dat   = w_busy ? i_m_dat[r_gidx*DW +: DW] : '0;
    assign o_s_sel   = w_busy ? i_m_sel[r_gidx*SW +: SW] : '0;
    assign o_s_we    = w_busy & i_m_we[r_gidx];
    assign o_m_ack   = r_grant & {N_MASTERS{w_ack | w_to}};
    assign o_m_err   = r_grant & {N_MASTERS{w_to}};
    assign o_m_rdt   = w_to ? '1 : i_s_rdt;
    assign o_grant   = r_grant;
    assign o_timeout = r_timeout;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_last    <= IW'(N_MASTERS - 1);
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to | (r_timeout & ~i_timeout_clr);
            if (!w_busy) begin
                if (|w_req) begin
                    r_state <= BUSY;
                    r_grant <= {{(N_MASTERS-1){1'b0}}, 1'b1} << w_win;
                    r_gidx  <= w_win;
                    r_last  <= w_win;
                    r_cnt   <= CW'(1);
                end else begin
                    r_grant <= '0;
                end
            end else if (w_ack | w_to | w_abort) begin
                r_state <= IDLE;
                r_grant <= '0;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_serv_wb_arbiter.sv
// tb_serv_wb_arbiter: directed checks of a round-robin and a fixed-priority
// arbiter instance driven by the same master/slave stimulus.
module tb_serv_wb_arbiter;
    logic        clk;
    logic        rst;
    logic [95:0] m_adr;
    logic [95:0] m_dat;
    logic [11:0] m_sel;
    logic [2:0]  m_we;
    logic [2:0]  m_cyc;
    logic [2:0]  m_stb;
    logic [31:0] s_rdt;
    logic        s_ack;
    logic        to_clr;

    logic [31:0] rr_rdt, fp_rdt, rr_s_adr, fp_s_adr, rr_s_dat, fp_s_dat;
    logic [2:0]  rr_ack, fp_ack, rr_err, fp_err, rr_grant, fp_grant;
    logic [3:0]  rr_s_sel, fp_s_sel;
    logic        rr_s_we, fp_s_we, rr_s_cyc, fp_s_cyc, rr_s_stb, fp_s_stb;
    logic        rr_to, fp_to;

    int n_checks = 0;
    int n_fail = 0;

    serv_wb_arbiter #(.N_MASTERS(3), .AW(32), .DW(32), .RR_MODE(1), .TIMEOUT(4)) dut (
        .clk(clk), .i_rst(rst), .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
        .i_m_we(m_we), .i_m_cyc(m_cyc), .i_m_stb(m_stb), .o_m_rdt(rr_rdt),
        .o_m_ack(rr_ack), .o_m_err(rr_err), .o_s_adr(rr_s_adr), .o_s_dat(rr_s_dat),
        .o_s_sel(rr_s_sel), .o_s_we(rr_s_we), .o_s_cyc(rr_s_cyc), .o_s_stb(rr_s_stb),
        .i_s_rdt(s_rdt), .i_s_ack(s_ack), .o_grant(rr_grant), .o_timeout(rr_to),
        .i_timeout_clr(to_clr)
    );

    serv_wb_arbiter #(.N_MASTERS(3), .AW(32), .DW(32), .RR_MODE(0), .TIMEOUT(4)) dut_fp (
        .clk(clk), .i_rst(rst), .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
        .i_m_we(m_we), .i_m_cyc(m_cyc), .i_m_stb(m_stb), .o_m_rdt(fp_rdt),
        .o_m_ack(fp_ack), .o_m_err(fp_err), .o_s_adr(fp_s_adr), .o_s_dat(fp_s_dat),
        .o_s_sel(fp_s_sel), .o_s_we(fp_s_we), .o_s_cyc(fp_s_cyc), .o_s_stb(fp_s_stb),
        .i_s_rdt(s_rdt), .i_s_ack(s_ack), .o_grant(fp_grant), .o_timeout(fp_to),
        .i_timeout_clr(to_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic req, input logic we, input logic [31:0] adr);
        m_cyc[k] = req;
        m_stb[k] = req;
        m_we[k] = we;
        m_adr[k*32 +: 32] = adr;
        m_dat[k*32 +: 32] = 32'hD000_0000 | k;
        m_sel[k*4 +: 4] = 4'hF;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [2:0] exp_rr;

    initial begin
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        s_rdt = '0; s_ack = 1'b0; to_clr = 1'b0; rst = 1'b0;
        do_reset();
        check("rst_grant", rr_grant, 3'b000);
        check("rst_cyc", rr_s_cyc, 1'b0);
        check("rst_timeout", rr_to, 1'b0);
        check("rst_ack", rr_ack, 3'b000);

        // single master read with ack in the third BUSY cycle
        set_m(1, 1'b1, 1'b0, 32'h100);
        #1;
        check("t1_idle_cyc", rr_s_cyc, 1'b0);
        tick();
        check("t1_b1_grant", rr_grant, 3'b010);
        check("t1_b1_cyc", rr_s_cyc, 1'b1);
        check("t1_b1_adr", rr_s_adr, 32'h100);
        check("t1_b1_sel", rr_s_sel, 4'hF);
        check("t1_b1_ack", rr_ack, 3'b000);
        tick();
        check("t1_b2_grant", rr_grant, 3'b010);
        tick();
        s_ack = 1'b1;
        s_rdt = 32'hCAFE_F00D;
        #1;
        check("t1_b3_ack", rr_ack, 3'b010);
        check("t1_b3_err", rr_err, 3'b000);
        check("t1_b3_rdt", rr_rdt, 32'hCAFE_F00D);
        tick();
        s_ack = 1'b0;
        set_m(1, 1'b0, 1'b0, 32'h0);
        #1;
        check("t1_after_grant", rr_grant, 3'b000);
        check("t1_after_cyc", rr_s_cyc, 1'b0);
        check("t1_after_ack", rr_ack, 3'b000);

        // all masters request continuously against a zero-wait slave
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h1000);
        set_m(1, 1'b1, 1'b1, 32'h1100);
        set_m(2, 1'b1, 1'b0, 32'h1200);
        s_ack = 1'b1;
        s_rdt = 32'h0BAD_BEEF;
        exp_rr = 3'b001;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rr_grant%0d", i), rr_grant, exp_rr);
            check($sformatf("rr_ack%0d", i), rr_ack, exp_rr);
            check($sformatf("rr_adr%0d", i), rr_s_adr,
                  exp_rr[0] ? 32'h1000 : exp_rr[1] ? 32'h1100 : 32'h1200);
            check($sformatf("fp_grant%0d", i), fp_grant, 3'b001);
            check($sformatf("fp_adr%0d", i), fp_s_adr, 32'h1000);
            tick();
            check($sformatf("rr_idle%0d", i), rr_grant, 3'b000);
            exp_rr = {exp_rr[1:0], exp_rr[2]};
        end
        check("rr_we_m1_idle", rr_s_we, 1'b0);
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0);
        set_m(2, 1'b0, 1'b0, 32'h0);

        // timeout: slave never acks
        tick();
        set_m(0, 1'b1, 1'b0, 32'h2000);
        tick();
        check("to_b1_grant", rr_grant, 3'b001);
        check("to_b1_err", rr_err, 3'b000);
        tick();
        tick();
        check("to_b3_ack", rr_ack, 3'b000);
        tick();
        check("to_b4_ack", rr_ack, 3'b001);
        check("to_b4_err", rr_err, 3'b001);
        check("to_b4_rdt", rr_rdt, 32'hFFFF_FFFF);
        check("to_b4_flag", rr_to, 1'b0);
        check("to_b4_fp_err", fp_err, 3'b001);
        set_m(0, 1'b0, 1'b0, 32'h0);
        tick();
        check("to_flag", rr_to, 1'b1);
        check("to_fp_flag", fp_to, 1'b1);
        check("to_grant", rr_grant, 3'b000);
        check("to_err_clear", rr_err, 3'b000);
        tick();
        check("to_sticky", rr_to, 1'b1);
        to_clr = 1'b1;
        tick();
        to_clr = 1'b0;
        check("to_cleared", rr_to, 1'b0);

        // ack arrives exactly in the timeout cycle
        set_m(1, 1'b1, 1'b0, 32'h3000);
        tick();
        check("ta_b1_grant", rr_grant, 3'b010);
        tick();
        tick();
        tick();
        s_ack = 1'b1;
        s_rdt = 32'h1234_5678;
        #1;
        check("ta_ack", rr_ack, 3'b010);
        check("ta_err", rr_err, 3'b000);
        check("ta_rdt", rr_rdt, 32'h1234_5678);
        tick();
        s_ack = 1'b0;
        set_m(1, 1'b0, 1'b0, 32'h0);
        #1;
        check("ta_flag", rr_to, 1'b0);
        check("ta_grant", rr_grant, 3'b000);

        // master 2 aborts in its second BUSY cycle
        set_m(2, 1'b1, 1'b0, 32'h4000);
        tick();
        check("ab_b1_grant", rr_grant, 3'b100);
        tick();
        set_m(2, 1'b0, 1'b0, 32'h4000);
        #1;
        check("ab_b2_ack", rr_ack, 3'b000);
        check("ab_b2_cyc", rr_s_cyc, 1'b1);
        tick();
        check("ab_grant", rr_grant, 3'b000);
        check("ab_cyc", rr_s_cyc, 1'b0);
        check("ab_err", rr_err, 3'b000);
        tick();
        tick();
        tick();
        check("ab_no_timeout", rr_to, 1'b0);

        // reset in the middle of a write, with a pending slave ack
        set_m(1, 1'b1, 1'b1, 32'h5000);
        tick();
        check("rs_b1_grant", rr_grant, 3'b010);
        check("rs_b1_we", rr_s_we, 1'b1);
        rst = 1'b1;
        s_ack = 1'b1;
        tick();
        check("rs_grant", rr_grant, 3'b000);
        check("rs_cyc", rr_s_cyc, 1'b0);
        check("rs_stb", rr_s_stb, 1'b0);
        check("rs_we", rr_s_we, 1'b0);
        check("rs_adr", rr_s_adr, 32'h0);
        check("rs_dat", rr_s_dat, 32'h0);
        check("rs_sel", rr_s_sel, 4'h0);
        check("rs_ack", rr_ack, 3'b000);
        check("rs_err", rr_err, 3'b000);
        rst = 1'b0;
        s_ack = 1'b0;
        set_m(1, 1'b0, 1'b0, 32'h0);
        set_m(0, 1'b1, 1'b0, 32'h6000);
        set_m(2, 1'b1, 1'b0, 32'h6200);
        tick();
        check("rs_rr_next", rr_grant, 3'b001);
        check("rs_fp_next", fp_grant, 3'b001);
        check("rs_adr_next", rr_s_adr, 32'h6000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serv_wb_arbiter.md
# serv_wb_arbiter

Parametrised Wishbone-classic arbiter that merges up to N_MASTERS bus masters onto one slave port. It lets the SERV core's instruction bus, data bus and the host wishbone port share a single memory/peripheral bus inside user_project_wrapper. It provides fixed-priority or round-robin grant selection and a per-transaction ack timeout with error signalling. The timeout keeps a stalled slave from hanging the core.

## Interface
- N_MASTERS, 3, number of master channels (2..8)
- AW, 32, address width
- DW, 32, data width (multiple of 8); SW = DW/8
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- TIMEOUT, 255, ack timeout in BUSY cycles; 0 disables timeout

- clk  in  1  single clock (wb_clk_i at wrapper level)
- i_rst  in  1  reset; synchronous, active-high
- i_m_adr  in  N_MASTERS*AW  master addresses, master k at [k*AW +: AW]
- i_m_dat  in  N_MASTERS*DW  master write data
- i_m_sel  in  N_MASTERS*SW  master byte selects
- i_m_we  in  N_MASTERS  master write enables
- i_m_cyc  in  N_MASTERS  master cycle
- i_m_stb  in  N_MASTERS  master strobe
- o_m_rdt  out  DW  read data, broadcast to all masters
- o_m_ack  out  N_MASTERS  per-master ack
- o_m_err  out  N_MASTERS  per-master timeout error
- o_s_adr  out  AW  slave address
- o_s_dat  out  DW  slave write data
- o_s_sel  out  SW  slave byte selects
- o_s_we  out  1  slave write enable
- o_s_cyc  out  1  slave cycle
- o_s_stb  out  1  slave strobe
- i_s_rdt  in  DW  slave read data
- i_s_ack  in  1  slave ack
- o_grant  out  N_MASTERS  registered one-hot grant, zero when idle
- o_timeout  out  1  sticky timeout flag
- i_timeout_clr  in  1  clears o_timeout

## Operation
- Request k = i_m_cyc[k] & i_m_stb[k].
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If any request is present, select a winner g, register o_grant = onehot(g) and go to BUSY.
  - If no request is present, stay in IDLE with o_grant = 0.
- Winner selection:
  - RR_MODE=0: lowest requesting index.
  - RR_MODE=1: first requesting index found searching upward from last+1, wrapping at N_MASTERS-1 to 0.
  - `last` updates only when a grant is issued and resets to N_MASTERS-1, so master 0 wins first after reset.
- BUSY:
  - o_s_cyc = o_s_stb = 1.
  - o_s_adr, o_s_dat, o_s_sel and o_s_we are muxed from master g.
  - o_m_rdt = i_s_rdt.
  - o_m_ack[g] = i_s_ack, combinational pass-through.
  - On i_s_ack, go to IDLE.
- Abort: if i_m_cyc[g] falls in BUSY without ack, go to IDLE. No ack or err is issued, and the slave sees cyc drop the next cycle.
- Timeout (TIMEOUT>0):
  - A counter of width clog2(TIMEOUT+1) counts BUSY cycles; it is 1 in the first BUSY cycle.
  - If the count equals TIMEOUT and i_s_ack=0, assert o_m_ack[g]=1, o_m_err[g]=1 and o_m_rdt = all-ones for that cycle.
  - Then go to IDLE and set o_timeout on the next edge.
  - Ack and timeout in the same cycle: the ack wins, with no err.
- o_timeout is cleared by i_timeout_clr. If a set and a clear occur in the same cycle, the set wins.
- Non-granted masters always see o_m_ack = o_m_err = 0.
- Reset takes effect at the next edge, including mid-transaction:
  - State returns to IDLE; o_grant, o_timeout, counter and all o_s_cyc/stb/we/adr/dat/sel are 0.
  - o_m_ack and o_m_err are 0.
  - The RR pointer is set to N_MASTERS-1.
  - A pending slave ack during reset is ignored.

## Timing
- Request sampled at edge t → o_grant and o_s_cyc high after edge t (cycle t+1).
- With a zero-wait slave (ack in the first BUSY cycle), each transaction takes 2 cycles: arbitration, then BUSY.
- One mandatory IDLE cycle follows every ack, err or abort before the next grant. Back-to-back throughput is therefore one transaction per 2 cycles.
- Slave-side outputs are combinational from the registered grant and the master inputs.
- o_m_ack and o_m_rdt are combinational from i_s_ack and i_s_rdt, with no added latency.

## Test plan
- Single master: m1 reads adr 0x100, slave acks in the 3rd BUSY cycle with 0xCAFEF00D → o_s_cyc up 1 cycle after request; o_m_ack[1] one cycle; o_m_rdt=0xCAFEF00D; o_grant=3'b010 during BUSY, 0 afterwards.
- Round-robin: RR_MODE=1, all 3 masters hold requests, zero-wait slave → grant order 0,1,2,0,… with an idle cycle between grants. RR_MODE=0 with the same stimulus → master 0 is granted every time.
- Timeout: TIMEOUT=4, slave never acks → o_m_ack[g] and o_m_err[g] pulse in the 4th BUSY cycle with o_m_rdt=0xFFFFFFFF; o_timeout=1 next cycle; i_timeout_clr pulse → 0.
- Ack on the timeout cycle: ack arrives exactly in BUSY cycle 4 → normal ack, o_m_err=0, o_timeout stays 0.
- Abort and reset: m2 drops cyc in BUSY cycle 2 → no ack, back to IDLE. In a separate run, i_rst asserted mid-BUSY → all outputs 0 after the edge; the next request from masters 0 and 2 grants master 0.
